// File: rtl/ledwalker_n.sv
// ledwalker_n -- single-LED walker for board status displays.
//
// A lit LED steps across NLEDS outputs once every STEP_CLOCKS clocks, either
// bouncing between the two ends or wrapping around in a selectable direction.
// The walk can be paused without losing its place in the current interval.
//
// Optional feature macro: LEDWALKER_TRAIL_EN
//   defined   -> the previously lit LED glows dimly (25 % duty from a 3-bit
//                free-running PWM counter), so o_led is one- or two-hot.
//   undefined -> no PWM logic, o_led is strictly one-hot.
//
// Ports:
//   i_clk      system clock, all state changes on its rising edge
//   i_reset_n  asynchronous active-low reset (release expected synchronous)
//   i_en       1 = walk, 0 = pause (interval counter and position hold)
//   i_mode     0 = bounce, 1 = wrap
//   i_dir      wrap direction: 0 = up (index increasing), 1 = down
//   o_led      LED drive, one bit per LED
//   o_pos      index of the lit (head) LED
//   o_strobe   one-cycle pulse in the cycle after each step edge
module ledwalker_n #(
   parameter  int NLEDS       = 8,
   parameter  int STEP_CLOCKS = 6_250_000,
   localparam int PW          = $clog2(NLEDS),
   localparam int CW          = $clog2(STEP_CLOCKS)
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_en,
   input  logic             i_mode,
   input  logic             i_dir,
   output logic [NLEDS-1:0] o_led,
   output logic [PW-1:0]    o_pos,
   output logic             o_strobe
);

   localparam logic [PW-1:0]    POS_LAST = PW'(NLEDS - 1);
   localparam logic [CW-1:0]    CNT_LAST = CW'(STEP_CLOCKS - 1);
   localparam logic [NLEDS-1:0] LED_ONE  = {{(NLEDS-1){1'b0}}, 1'b1};

   logic [CW-1:0]    cnt_q, cnt_d;
   logic [PW-1:0]    pos_q, pos_d;
   logic             dir_q, dir_d;      // 0 = moving up, 1 = moving down
   logic [NLEDS-1:0] led_q, led_d;      // head LED, registered one-hot
   logic             strobe_q, strobe_d;
   logic             step;

   assign step = i_en && (cnt_q == CNT_LAST);

   // Interval counter: holds while paused so the interval resumes, not restarts.
   always_comb begin
      cnt_d = cnt_q;
      if (i_en) begin
         cnt_d = step ? '0 : cnt_q + CW'(1);
      end
   end

   // Position / direction update. The end tests use >= / == so that an
   // out-of-range value can never persist, even for non-power-of-2 NLEDS.
   always_comb begin
      pos_d = pos_q;
      dir_d = dir_q;
      if (step) begin
         if (i_mode) begin
            dir_d = i_dir;
            if (!i_dir) begin
               pos_d = (pos_q >= POS_LAST) ? '0 : pos_q + PW'(1);
            end else begin
               pos_d = (pos_q == '0) ? POS_LAST : pos_q - PW'(1);
            end
         end else if (!dir_q) begin
            if (pos_q >= POS_LAST) begin
               pos_d = POS_LAST - PW'(1);
               dir_d = 1'b1;
            end else begin
               pos_d = pos_q + PW'(1);
            end
         end else begin
            if (pos_q == '0) begin
               pos_d = PW'(1);
               dir_d = 1'b0;
            end else begin
               pos_d = pos_q - PW'(1);
            end
         end
      end
   end

   // Decoded from next-state so the registered LED always matches o_pos.
   always_comb begin
      led_d    = LED_ONE << pos_d;
      strobe_d = step;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cnt_q    <= '0;
         pos_q    <= '0;
         dir_q    <= 1'b0;
         led_q    <= LED_ONE;
         strobe_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         pos_q    <= pos_d;
         dir_q    <= dir_d;
         led_q    <= led_d;
         strobe_q <= strobe_d;
      end
   end

`ifdef LEDWALKER_TRAIL_EN
   logic [2:0]       pwm_q, pwm_d;
   logic [NLEDS-1:0] trail_q, trail_d;

   // The trail remembers the head that was lit before the latest step.
   always_comb begin
      pwm_d   = pwm_q + 3'd1;
      trail_d = step ? led_q : trail_q;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         pwm_q   <= '0;
         trail_q <= '0;
      end else begin
         pwm_q   <= pwm_d;
         trail_q <= trail_d;
      end
   end

   // Trail shown in 2 of every 8 cycles -> 25 % duty.
   always_comb begin
      o_led = led_q | ((pwm_q < 3'd2) ? trail_q : '0);
   end
`else
   always_comb begin
      o_led = led_q;
   end
`endif

   assign o_pos    = pos_q;
   assign o_strobe = strobe_q;

endmodule

// File: tb/tb_ledwalker_n.sv
// Testbench for ledwalker_n (NLEDS=8, STEP_CLOCKS=4). Directed scenarios plus a
// randomized run checked against a phase-based reference model.
module tb_ledwalker_n;

   localparam int N  = 8;
   localparam int SC = 4;
   localparam int PW = $clog2(N);

   // ---------------- clock / reset ----------------
   logic         clk;
   logic         rst_n;
   logic         en;
   logic         mode;
   logic         dir;
   logic [N-1:0] o_led;
   logic [PW-1:0] o_pos;
   logic         o_strobe;

   int checks   = 0;
   int failures = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   ledwalker_n #(.NLEDS(N), .STEP_CLOCKS(SC)) dut (
      .i_clk    (clk),
      .i_reset_n(rst_n),
      .i_en     (en),
      .i_mode   (mode),
      .i_dir    (dir),
      .o_led    (o_led),
      .o_pos    (o_pos),
      .o_strobe (o_strobe)
   );

   // ---------------- reference model ----------------
   // Bounce is modelled as a phase 0..2N-3 around the cycle; wrap as +/-1 mod N.
   int           m_cnt, m_pos, m_pwm, m_strobe, ph;
   bit           m_down, m_stp;
   logic [N-1:0] m_trail;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt = 0; m_pos = 0; m_down = 0; m_strobe = 0; m_pwm = 0; m_trail = '0;
      end else begin
         m_stp = en && (m_cnt == SC - 1);
         if (m_stp) begin
            m_trail = N'(1) << m_pos;
            if (mode) begin
               m_pos  = dir ? (m_pos + N - 1) % N : (m_pos + 1) % N;
               m_down = dir;
            end else begin
               ph     = m_down ? ((m_pos == 0) ? 0 : 2 * N - 2 - m_pos) : m_pos;
               ph     = (ph + 1) % (2 * N - 2);
               m_pos  = (ph < N) ? ph : 2 * N - 2 - ph;
               m_down = (ph >= N - 1);
            end
         end
         if (en) m_cnt = m_stp ? 0 : m_cnt + 1;
         m_strobe = m_stp ? 1 : 0;
         m_pwm    = (m_pwm + 1) % 8;
      end
   end

   function automatic logic [N-1:0] exp_led();
      logic [N-1:0] e;
      e = N'(1) << m_pos;
`ifdef LEDWALKER_TRAIL_EN
      if (m_pwm < 2) e = e | m_trail;
`endif
      return e;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic do_reset(input logic en_v, input logic mode_v, input logic dir_v);
      @(negedge clk);
      rst_n = 1'b0;
      en    = 1'b0;
      @(negedge clk);
      @(negedge clk);
      en    = en_v;
      mode  = mode_v;
      dir   = dir_v;
      rst_n = 1'b1;
   endtask

   // Waits (bounded) for a strobe sampled at a falling edge; returns cycles waited.
   task automatic wait_strobe(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!o_strobe && cyc < 50);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; mode = 1'b0; dir = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (o_led !== 8'h01 || o_pos !== '0 || o_strobe !== 1'b0) begin
         failures++;
         $display("FAIL reset: led=%h pos=%0d strobe=%b, want led=01 pos=0 strobe=0",
                  o_led, o_pos, o_strobe);
      end
   endtask

   task automatic test_first_step();
      @(negedge clk);
      en = 1'b1; mode = 1'b0; dir = 1'b0; rst_n = 1'b1;
      for (int i = 1; i <= SC; i++) begin
         @(negedge clk);
         checks++;
         if (i < SC && (o_strobe !== 1'b0 || o_led !== 8'h01)) begin
            failures++;
            $display("FAIL first_step_early edge %0d: led=%h strobe=%b, want led=01 strobe=0",
                     i, o_led, o_strobe);
         end else if (i == SC && (o_strobe !== 1'b1 || o_led !== 8'h02)) begin
            failures++;
            $display("FAIL first_step edge %0d: led=%h strobe=%b, want led=02 strobe=1",
                     i, o_led, o_strobe);
         end
      end
   endtask

   task automatic test_bounce_sweep();
      logic [PW-1:0] exp_q[$];
      logic [PW-1:0] e;
      int cyc;
      for (int p = 1; p < N; p++) exp_q.push_back(PW'(p));
      for (int p = N - 2; p >= 0; p--) exp_q.push_back(PW'(p));
      exp_q.push_back(PW'(1));
      do_reset(1'b1, 1'b0, 1'b0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         wait_strobe(cyc);
         checks++;
         if (cyc != SC || o_pos !== e || o_led !== (N'(1) << e)) begin
            failures++;
            $display("FAIL bounce_sweep: cycles=%0d pos=%0d led=%h, want cycles=%0d pos=%0d",
                     cyc, o_pos, o_led, SC, e);
         end
      end
      @(negedge clk);
      checks++;
      if (o_strobe !== 1'b0) begin
         failures++;
         $display("FAIL strobe_width: strobe=%b one cycle after step, want 0", o_strobe);
      end
   endtask

   task automatic test_wrap_dir();
      int cyc;
      int exp_p[3] = '{7, 6, 5};
      do_reset(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         wait_strobe(cyc);
         checks++;
         if (cyc != SC || o_pos !== PW'(exp_p[i])) begin
            failures++;
            $display("FAIL wrap_down: cycles=%0d pos=%0d, want cycles=%0d pos=%0d",
                     cyc, o_pos, SC, exp_p[i]);
         end
      end
      @(negedge clk);
      @(negedge clk);
      dir = 1'b0;                       // change mid-interval
      wait_strobe(cyc);
      checks++;
      if (cyc != 2 || o_pos !== PW'(6)) begin
         failures++;
         $display("FAIL wrap_dir_switch: cycles=%0d pos=%0d, want cycles=2 pos=6", cyc, o_pos);
      end
      wait_strobe(cyc);
      checks++;
      if (o_pos !== PW'(7)) begin
         failures++;
         $display("FAIL wrap_up: pos=%0d, want 7", o_pos);
      end
      @(negedge clk);
      mode = 1'b0;                      // bounce at the top end while going up
      wait_strobe(cyc);
      checks++;
      if (o_pos !== PW'(6) || o_led !== 8'h40) begin
         failures++;
         $display("FAIL mode_switch: pos=%0d led=%h, want pos=6 led=40", o_pos, o_led);
      end
   endtask

   task automatic test_pause();
      int cyc;
      do_reset(1'b1, 1'b0, 1'b0);
      wait_strobe(cyc);                 // pos 1, cnt 0
      @(negedge clk);
      @(negedge clk);                   // cnt 2
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (o_strobe !== 1'b0 || o_pos !== PW'(1)) begin
            failures++;
            $display("FAIL pause_hold: strobe=%b pos=%0d, want strobe=0 pos=1", o_strobe, o_pos);
         end
      end
      en = 1'b1;
      wait_strobe(cyc);
      checks++;
      if (cyc != 2 || o_pos !== PW'(2)) begin
         failures++;
         $display("FAIL pause_resume: cycles=%0d pos=%0d, want cycles=2 pos=2", cyc, o_pos);
      end
      for (int i = 0; i < 3; i++) @(negedge clk);   // cnt at its last value
      en = 1'b0;                        // drop enable on the would-be step cycle
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (o_strobe !== 1'b0 || o_pos !== PW'(2)) begin
            failures++;
            $display("FAIL pause_at_last: strobe=%b pos=%0d, want strobe=0 pos=2", o_strobe, o_pos);
         end
      end
      en = 1'b1;
      wait_strobe(cyc);
      checks++;
      if (cyc != 1 || o_pos !== PW'(3)) begin
         failures++;
         $display("FAIL resume_at_last: cycles=%0d pos=%0d, want cycles=1 pos=3", cyc, o_pos);
      end
   endtask

   task automatic test_async_reset();
      int cyc;
      do_reset(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) wait_strobe(cyc);
      checks++;
      if (o_pos !== PW'(5)) begin
         failures++;
         $display("FAIL async_setup: pos=%0d, want 5", o_pos);
      end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (o_led !== 8'h01 || o_pos !== '0 || o_strobe !== 1'b0) begin
         failures++;
         $display("FAIL async_mid_interval: led=%h pos=%0d strobe=%b, want 01 0 0",
                  o_led, o_pos, o_strobe);
      end
      do_reset(1'b1, 1'b0, 1'b0);
      wait_strobe(cyc);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (o_led !== 8'h01 || o_pos !== '0 || o_strobe !== 1'b0) begin
         failures++;
         $display("FAIL async_mid_strobe: led=%h pos=%0d strobe=%b, want 01 0 0",
                  o_led, o_pos, o_strobe);
      end
   endtask

   task automatic test_random();
      do_reset(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         checks++;
         if (o_pos !== PW'(m_pos) || o_led !== exp_led() || o_strobe !== 1'(m_strobe)) begin
            failures++;
            $display("FAIL random cycle %0d: pos=%0d led=%h strobe=%b, want pos=%0d led=%h strobe=%0d",
                     i, o_pos, o_led, o_strobe, m_pos, exp_led(), m_strobe);
         end
`ifndef LEDWALKER_TRAIL_EN
         checks++;
         if (!$onehot(o_led)) begin
            failures++;
            $display("FAIL onehot cycle %0d: led=%h, want exactly one bit set", i, o_led);
         end
`endif
         en = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 15) == 0) mode = ~mode;
         if ($urandom_range(0, 7) == 0) dir = ~dir;
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_first_step();
      test_bounce_sweep();
      test_wrap_dir();
      test_pause();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500_000;
      $display("FAIL timeout: simulation did not complete within time limit");
      $fatal(1, "timeout");
   end

endmodule
